// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map and I/O address field positions for the GPIO bank
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_OUT   = 3'd0,
    REG_DIR   = 3'd1,
    REG_IN    = 3'd2,
    REG_RISE  = 3'd3,
    REG_FALL  = 3'd4,
    REG_IEN   = 3'd5,
    REG_ISTAT = 3'd6,
    REG_RSVD  = 3'd7
  } reg_idx_t;

  // io_address is numbered [0:15] with bit 0 as the MSB
  localparam int ADDR_CHAN_FIRST = 10;
  localparam int ADDR_CHAN_LAST  = 12;
  localparam int ADDR_REG_FIRST  = 13;
  localparam int ADDR_REG_LAST   = 15;

  localparam logic [1:0] ARM_CYCLES = 2'd3;

endpackage

// File: rtl/gpio_if.sv
// rtl/gpio_if.sv - CPU I/O strobe bus into the GPIO bank
interface gpio_if;

  logic        io_read_enable;
  logic        io_write_enable;
  logic [0:15] io_address;
  logic [0:15] io_write_data;
  logic [0:15] io_read_data;

  modport master (
    output io_read_enable, io_write_enable, io_address, io_write_data,
    input  io_read_data
  );

  modport slave (
    input  io_read_enable, io_write_enable, io_address, io_write_data,
    output io_read_data
  );

endinterface

// File: rtl/gpio_channel.sv
// rtl/gpio_channel.sv - one GPIO channel: OUT/DIR/IEN registers, input synchronizer,
// edge capture with write-one-to-clear status
module gpio_channel
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             armed,
  input  logic             wr_en,
  input  reg_idx_t         reg_idx,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] rdata,
  output logic             istat_any
);

  logic [WIDTH-1:0] out_q, dir_q, ien_q;
  logic [WIDTH-1:0] sync_q, in_q, prev_q;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic [WIDTH-1:0] rise_set, fall_set, rise_clr, fall_clr, istat;

  always_comb begin
    rise_set = armed ? (in_q & ~prev_q) : '0;
    fall_set = armed ? (~in_q & prev_q) : '0;
    rise_clr = (wr_en && reg_idx == REG_RISE) ? wdata : '0;
    fall_clr = (wr_en && reg_idx == REG_FALL) ? wdata : '0;
  end

  assign istat     = (rise_q | fall_q) & ien_q;
  assign istat_any = |istat;
  assign pin_out   = out_q;
  assign pin_oe    = dir_q;

  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      out_q  <= '0;
      dir_q  <= '0;
      ien_q  <= '0;
      sync_q <= '0;
      in_q   <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= pin_in;
      in_q   <= sync_q;
      prev_q <= in_q;
      if (wr_en && reg_idx == REG_OUT) out_q <= wdata;
      if (wr_en && reg_idx == REG_DIR) dir_q <= wdata;
      if (wr_en && reg_idx == REG_IEN) ien_q <= wdata;
      // a fresh edge on the same cycle as its clear keeps the bit set
      rise_q <= (rise_q & ~rise_clr) | rise_set;
      fall_q <= (fall_q & ~fall_clr) | fall_set;
    end
  end

  always_comb begin
    case (reg_idx)
      REG_OUT:   rdata = out_q;
      REG_DIR:   rdata = dir_q;
      REG_IN:    rdata = in_q;
      REG_RISE:  rdata = rise_q;
      REG_FALL:  rdata = fall_q;
      REG_IEN:   rdata = ien_q;
      REG_ISTAT: rdata = istat;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - bank of CHANNELS GPIO channels behind a one-hot selected CPU I/O port
// with a shared level interrupt; pad tristates live outside this block
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int SEL_BIT  = 0
) (
  input  logic                      clk,
  input  logic                      resetq,
  gpio_if.slave                     bus,
  input  logic [CHANNELS*WIDTH-1:0] pin_in,
  output logic [CHANNELS*WIDTH-1:0] pin_out,
  output logic [CHANNELS*WIDTH-1:0] pin_oe,
  output logic                      irq
);

  logic                sel;
  logic [2:0]          chan;
  reg_idx_t            reg_idx;
  logic                chan_ok;
  logic [WIDTH-1:0]    wdata;
  logic [1:0]          arm_cnt;
  logic                armed;
  logic [WIDTH-1:0]    ch_rdata [CHANNELS];
  logic [CHANNELS-1:0] ch_istat;
  logic [WIDTH-1:0]    rsel;
  logic                unused_bus_bits;

  assign sel     = bus.io_address[SEL_BIT];
  assign chan    = bus.io_address[ADDR_CHAN_FIRST:ADDR_CHAN_LAST];
  assign reg_idx = reg_idx_t'(bus.io_address[ADDR_REG_FIRST:ADDR_REG_LAST]);
  assign chan_ok = sel && (int'(chan) < CHANNELS);
  assign wdata   = bus.io_write_data[16-WIDTH:15];
  assign armed   = (arm_cnt == ARM_CYCLES);

  assign unused_bus_bits = ^{bus.io_address, bus.io_write_data};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gpio_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .resetq   (resetq),
      .armed    (armed),
      .wr_en    (bus.io_write_enable && chan_ok && chan == 3'(c)),
      .reg_idx  (reg_idx),
      .wdata    (wdata),
      .pin_in   (pin_in[c*WIDTH +: WIDTH]),
      .pin_out  (pin_out[c*WIDTH +: WIDTH]),
      .pin_oe   (pin_oe[c*WIDTH +: WIDTH]),
      .rdata    (ch_rdata[c]),
      .istat_any(ch_istat[c])
    );
  end

  always_comb begin
    rsel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan == 3'(c)) rsel = ch_rdata[c];
    end
  end

  // Edge capture stays off until the synchronizer and prev stages hold real pad data
  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      arm_cnt          <= 2'd0;
      irq              <= 1'b0;
      bus.io_read_data <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      irq <= |ch_istat;
      if (bus.io_read_enable) bus.io_read_data <= chan_ok ? 16'(rsel) : 16'h0000;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - self-checking bench for gpio_bank: directed scenarios plus random
// traffic against a behavioural model
module tb_gpio_bank;
  import gpio_pkg::*;

  localparam int CH   = 3;
  localparam int W    = 8;
  localparam int SB   = 0;
  localparam int NP   = CH * W;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          resetq = 1'b1;
  logic [NP-1:0] pin_in = '0;
  logic [NP-1:0] pin_out, pin_oe;
  logic          irq;
  logic          chk_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  gpio_if bus ();

  gpio_bank #(.CHANNELS(CH), .WIDTH(W), .SEL_BIT(SB)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .pin_oe (pin_oe),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: registers as plain integers, pads as a three-deep sample history
  int            m_out[CH], m_dir[CH], m_ien[CH], m_rise[CH], m_fall[CH];
  logic [NP-1:0] h0, h1, h2;
  int            n_rel;
  logic [15:0]   m_rd;
  logic          m_irq;

  function automatic int field(input logic [NP-1:0] v, input int c);
    logic [NP-1:0] t;
    t = v >> (c * W);
    return int'(t[W-1:0]);
  endfunction

  function automatic int reg_val(input int c, input int r);
    case (r)
      0: return m_out[c];
      1: return m_dir[c];
      2: return field(h1, c);
      3: return m_rise[c];
      4: return m_fall[c];
      5: return m_ien[c];
      6: return (m_rise[c] | m_fall[c]) & m_ien[c];
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin : mdl
    logic [15:0] a;
    logic        ok, any;
    int          c, r, wd, in_v, pv, rs, fs, cr, cf;
    if (resetq) begin
      for (int k = 0; k < CH; k++) begin
        m_out[k] = 0; m_dir[k] = 0; m_ien[k] = 0; m_rise[k] = 0; m_fall[k] = 0;
      end
      h0 = '0; h1 = '0; h2 = '0;
      n_rel = 0; m_rd = 16'h0; m_irq = 1'b0;
    end else begin
      a  = bus.io_address;
      c  = int'(a[5:3]);
      r  = int'(a[2:0]);
      wd = int'(bus.io_write_data) & MASK;
      ok = a[15-SB] && (c < CH);
      if (bus.io_read_enable) m_rd = ok ? 16'(reg_val(c, r)) : 16'h0;
      any = 1'b0;
      for (int k = 0; k < CH; k++)
        if (((m_rise[k] | m_fall[k]) & m_ien[k]) != 0) any = 1'b1;
      m_irq = any;
      for (int k = 0; k < CH; k++) begin
        in_v = field(h1, k);
        pv   = field(h2, k);
        rs = (n_rel >= 3) ? (in_v & ~pv & MASK) : 0;
        fs = (n_rel >= 3) ? (~in_v & pv & MASK) : 0;
        cr = 0; cf = 0;
        if (bus.io_write_enable && ok && c == k) begin
          if (r == 0) m_out[k] = wd;
          if (r == 1) m_dir[k] = wd;
          if (r == 5) m_ien[k] = wd;
          if (r == 3) cr = wd;
          if (r == 4) cf = wd;
        end
        m_rise[k] = (m_rise[k] & ~cr) | rs;
        m_fall[k] = (m_fall[k] & ~cf) | fs;
      end
      h2 = h1; h1 = h0; h0 = pin_in;
      if (n_rel < 3) n_rel++;
    end
  end

  always @(negedge clk) begin : cmp
    logic [NP-1:0] eo, ee;
    logic [15:0]   er;
    logic          ei;
    if (chk_en) begin
      eo = '0; ee = '0; er = 16'h0; ei = 1'b0;
      if (!resetq) begin
        for (int k = 0; k < CH; k++) begin
          eo[k*W +: W] = W'(m_out[k]);
          ee[k*W +: W] = W'(m_dir[k]);
        end
        er = m_rd;
        ei = m_irq;
      end
      chk("pin_out", 32'(pin_out), 32'(eo));
      chk("pin_oe", 32'(pin_oe), 32'(ee));
      chk("io_read_data", 32'(bus.io_read_data), 32'(er));
      chk("irq", 32'(irq), 32'(ei));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] mk_addr(input logic s, input int c, input int r);
    logic [15:0] a;
    a = 16'h0;
    a[15-SB] = s;
    a[5:3] = 3'(c);
    a[2:0] = 3'(r);
    return a;
  endfunction

  task automatic wr(input logic s, input int c, input int r, input int d);
    bus.io_read_enable  = 1'b0;
    bus.io_write_enable = 1'b1;
    bus.io_address      = mk_addr(s, c, r);
    bus.io_write_data   = 16'(d);
    cyc(1);
    bus.io_write_enable = 1'b0;
  endtask

  task automatic rd(input logic s, input int c, input int r, output logic [15:0] v);
    bus.io_write_enable = 1'b0;
    bus.io_read_enable  = 1'b1;
    bus.io_address      = mk_addr(s, c, r);
    cyc(1);
    bus.io_read_enable = 1'b0;
    v = bus.io_read_data;
  endtask

  initial begin
    logic [15:0] v;
    int          c;
    bus.io_read_enable  = 1'b0;
    bus.io_write_enable = 1'b0;
    bus.io_address      = 16'h0;
    bus.io_write_data   = 16'h0;

    // reset with all pads high
    resetq = 1'b1;
    pin_in = '1;
    cyc(3);
    chk_en = 1'b1;
    cyc(1);
    chk("reset_pin_oe", 32'(pin_oe), 32'h0);
    chk("reset_rdata", 32'(bus.io_read_data), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    resetq = 1'b0;
    cyc(5);
    rd(1'b1, 0, int'(REG_RISE), v);
    chk("no_rise_after_arm", 32'(v), 32'h0);

    // output path on channel 1
    wr(1'b1, 1, int'(REG_DIR), 'hFF);
    chk("dir_ch1", 32'(pin_oe[15:8]), 32'hFF);
    wr(1'b1, 1, int'(REG_OUT), 'hA5);
    chk("out_ch1", 32'(pin_out[15:8]), 32'hA5);
    rd(1'b1, 1, int'(REG_OUT), v);
    chk("read_out_ch1", 32'(v), 32'h00A5);

    // drop pads, clear resulting falls, enable bit 0 interrupt
    pin_in = '0;
    cyc(6);
    for (int k = 0; k < CH; k++) wr(1'b1, k, int'(REG_FALL), 'hFF);
    wr(1'b1, 0, int'(REG_IEN), 'h01);

    // input latency and interrupt on a rising bit 0
    pin_in[0] = 1'b1;
    cyc(1);
    rd(1'b1, 0, int'(REG_IN), v);
    chk("in_not_yet", 32'(v), 32'h0);
    rd(1'b1, 0, int'(REG_IN), v);
    chk("in_visible", 32'(v), 32'h1);
    chk("irq_before_rise", 32'(irq), 32'h0);
    rd(1'b1, 0, int'(REG_RISE), v);
    chk("rise_set", 32'(v), 32'h1);
    chk("irq_after_rise", 32'(irq), 32'h1);
    wr(1'b1, 0, int'(REG_RISE), 'h01);
    chk("irq_lag_clear", 32'(irq), 32'h1);
    cyc(1);
    chk("irq_cleared", 32'(irq), 32'h0);

    // set wins over clear on the same bit
    pin_in[0] = 1'b0;
    cyc(1);
    pin_in[0] = 1'b1;
    cyc(2);
    wr(1'b1, 0, int'(REG_RISE), 'h01);
    rd(1'b1, 0, int'(REG_RISE), v);
    chk("set_wins", 32'(v), 32'h1);
    wr(1'b1, 0, int'(REG_FALL), 'h01);
    cyc(1);
    chk("irq_held_by_rise", 32'(irq), 32'h1);

    // decode: deselected, out-of-range channel, reserved register
    wr(1'b0, 0, int'(REG_OUT), 'hFF);
    wr(1'b1, CH, int'(REG_OUT), 'hFF);
    wr(1'b1, 1, int'(REG_RSVD), 'hFF);
    chk("decode_no_write", 32'(pin_out), 32'h00A500);
    rd(1'b0, 1, int'(REG_OUT), v);
    chk("read_unselected", 32'(v), 32'h0);
    rd(1'b1, CH, int'(REG_OUT), v);
    chk("read_bad_chan", 32'(v), 32'h0);
    rd(1'b1, 1, int'(REG_RSVD), v);
    chk("read_reserved", 32'(v), 32'h0);

    // random traffic, including resets landing mid-access
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, CH - 1));
      bus.io_read_enable  = ($urandom_range(0, 1) == 1);
      bus.io_write_enable = ($urandom_range(0, 2) == 0);
      bus.io_address      = mk_addr($urandom_range(0, 7) != 0, c, int'($urandom_range(0, 7)));
      bus.io_write_data   = 16'($urandom);
      if ($urandom_range(0, 2) == 0) pin_in = pin_in ^ (NP'(1) << $urandom_range(0, NP - 1));
      if ($urandom_range(0, 19) == 0) pin_in = pin_in ^ NP'($urandom);
      if (resetq) resetq = 1'b0;
      else if ($urandom_range(0, 299) == 0) resetq = 1'b1;
      cyc(1);
    end
    bus.io_read_enable  = 1'b0;
    bus.io_write_enable = 1'b0;
    resetq = 1'b0;
    cyc(4);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
